// File: rtl/demux_1ne5_wb.sv
// demux_1ne5_wb: registered 1-to-5 write-back distributor.
// One held word, one-hot valid, sticky bad-code flag, delivery counter.
module demux_1ne5_wb #(
   parameter int WIDTH = 24,
   parameter int CNT_W = 16
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [WIDTH-1:0] Hyrja,
   input  logic [2:0]       S,
   input  logic             HyrjaValid,
   output logic             HyrjaReady,
   output logic [WIDTH-1:0] Dalja,
   output logic [4:0]       DaljaValid,
   input  logic [4:0]       DaljaReady,
   output logic             Gabim,
   output logic [2:0]       GabimKodi,
   input  logic             GabimPastro,
   output logic [CNT_W-1:0] Numeruesi
);

   typedef enum logic {BOSH, PLOT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dalja_q, dalja_d;
   logic [4:0]       valid_q, valid_d;
   logic             gabim_q, gabim_d;
   logic [2:0]       kodi_q, kodi_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       drain;
   logic       accept;
   logic       legal;
   logic [4:0] onehot;

   // Only the selected destination's ready can complete a delivery.
   assign drain      = (state_q == PLOT) && |(valid_q & DaljaReady);
   assign HyrjaReady = (state_q == BOSH) || drain;
   assign accept     = HyrjaValid && HyrjaReady;

   // Destination code to one-hot; 100, 110, 111 have no consumer.
   always_comb begin
      onehot = 5'b00000;
      legal  = 1'b1;
      case (S)
         3'b000:  onehot = 5'b00001;
         3'b001:  onehot = 5'b00010;
         3'b010:  onehot = 5'b00100;
         3'b011:  onehot = 5'b01000;
         3'b101:  onehot = 5'b10000;
         default: legal  = 1'b0;
      endcase
   end

   // Next state: drain empties, legal accept reloads, bad code only flags.
   always_comb begin
      state_d = state_q;
      dalja_d = dalja_q;
      valid_d = valid_q;
      gabim_d = gabim_q;
      kodi_d  = kodi_q;
      cnt_d   = cnt_q;
      if (drain) begin
         cnt_d   = cnt_q + CNT_W'(1);
         valid_d = 5'b00000;
         state_d = BOSH;
      end
      if (accept && legal) begin
         dalja_d = Hyrja;
         valid_d = onehot;
         state_d = PLOT;
      end
      if (accept && !legal) begin
         gabim_d = 1'b1;
         if (!gabim_q || GabimPastro) begin
            kodi_d = S;
         end
      end else if (GabimPastro) begin
         gabim_d = 1'b0;
         kodi_d  = 3'b000;
      end
   end

   // State and registered outputs; reset drops any held word.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= BOSH;
         dalja_q <= '0;
         valid_q <= 5'b00000;
         gabim_q <= 1'b0;
         kodi_q  <= 3'b000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         dalja_q <= dalja_d;
         valid_q <= valid_d;
         gabim_q <= gabim_d;
         kodi_q  <= kodi_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Dalja      = dalja_q;
   assign DaljaValid = valid_q;
   assign Gabim      = gabim_q;
   assign GabimKodi  = kodi_q;
   assign Numeruesi  = cnt_q;

endmodule
